// File: rtl/fifo_v3_pkg.sv
// fifo_v3_pkg: shared widths and defaults for the fifo_v3 queue.
//   ptr_w(depth) : pointer width for a queue of 'depth' entries
//   cnt_w(depth) : occupancy counter width (must hold 0..depth)
//   DEF_*        : default entry width and depth
package fifo_v3_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_AF_THRESH  = 6;
  localparam int unsigned DEF_AE_THRESH  = 2;

  // Depth >= 2 is required, so $clog2 is at least 1; the guard keeps
  // the pointer 1 bit wide even for a misconfigured depth of 1.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so that usage == depth is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_v3_wrap_ptr.sv
// fifo_v3_wrap_ptr: circular pointer for fifo_v3 storage.
//   clk_i : clock
//   rst_i : synchronous reset, active-high
//   clr_i : synchronous clear (flush)
//   inc_i : advance by one
//   ptr_o : current pointer, 0..DEPTH-1
// Wraps explicitly at DEPTH-1 so non-power-of-two depths never index past
// the last entry.
module fifo_v3_wrap_ptr
  import fifo_v3_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: parametrised single-clock FIFO with fill level, programmable
// almost-full/almost-empty, sticky overflow/underflow and optional
// first-word fall-through.
//   clk_i / rst_i    : clock, synchronous active-high reset
//   flush_i          : clear pointers, usage and error flags
//   push_i / data_i  : write request and data
//   pop_i / data_o   : read request and head entry (0 when empty)
//   full_o, empty_o, almost_full_o, almost_empty_o, usage_o : status
//   overflow_o / underflow_o : sticky error flags
// Optional feature macro: FIFO_V3_FALL_THROUGH_EN. When defined, a push
// into an empty FIFO is visible on data_o in the same cycle, and a pop in
// that cycle consumes it without storing it.
module fifo_v3
  import fifo_v3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH,
  localparam int unsigned ADDR_W    = ptr_w(DEPTH),
  localparam int unsigned CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]      r_usage;
  logic                  r_ovf;
  logic                  r_udf;

  logic [ADDR_W-1:0]     w_wr_ptr;
  logic [ADDR_W-1:0]     w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [DATA_WIDTH-1:0] w_head;

  // Status from registered occupancy only.
  assign w_full  = (r_usage == FULL_CNT);
  assign w_empty = (r_usage == '0);
  assign w_head  = w_empty ? '0 : r_mem[w_rd_ptr];

`ifdef FIFO_V3_FALL_THROUGH_EN
  logic w_ft;
  logic w_bypass;

  // Push into an empty queue is presented straight through; with a pop in
  // the same cycle the word is handed over and never stored.
  assign w_ft       = w_empty && push_i;
  assign w_bypass   = w_ft && pop_i;
  assign w_push_acc = push_i && !w_full && !w_bypass;
  assign w_pop_acc  = pop_i && !w_empty;
  assign w_ovf_evt  = push_i && w_full;
  assign w_udf_evt  = pop_i && w_empty && !push_i;
  assign empty_o    = w_empty && !w_ft;
  assign data_o     = w_ft ? data_i : w_head;
`else
  assign w_push_acc = push_i && !w_full;
  assign w_pop_acc  = pop_i && !w_empty;
  // Full with push+pop still drops the push: full_o is state-based.
  assign w_ovf_evt  = push_i && w_full;
  assign w_udf_evt  = pop_i && w_empty;
  assign empty_o    = w_empty;
  assign data_o     = w_head;
`endif

  fifo_v3_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_push_acc),
    .ptr_o (w_wr_ptr)
  );

  fifo_v3_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_pop_acc),
    .ptr_o (w_rd_ptr)
  );

  // Storage is not reset; contents are only observable through w_head,
  // which is gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && w_push_acc) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_usage <= '0;
    end else if (w_push_acc && !w_pop_acc) begin
      r_usage <= r_usage + CNT_W'(1);
    end else if (!w_push_acc && w_pop_acc) begin
      r_usage <= r_usage - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_udf_evt) r_udf <= 1'b1;
    end
  end

  assign full_o         = w_full;
  assign almost_full_o  = (r_usage >= AF_CNT);
  assign almost_empty_o = (r_usage <= AE_CNT);
  assign usage_o        = r_usage;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule

// File: tb/tb_fifo_v3.sv
// Directed bench for fifo_v3 at DEPTH=5, AF_THRESH=4, AE_THRESH=1, DATA_WIDTH=8.
module tb_fifo_v3;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          push_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          pop_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [CW-1:0] usage_o;
  logic          overflow_o, underflow_o;

  int n_checks = 0;
  int n_errors = 0;

  fifo_v3 #(
    .DATA_WIDTH (DW),
    .DEPTH      (5),
    .AF_THRESH  (4),
    .AE_THRESH  (1)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .push_i         (push_i),
    .data_i         (data_i),
    .pop_i          (pop_i),
    .data_o         (data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .usage_o        (usage_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [31:0] ovf, input logic [31:0] udf);
    chk({tag, "_ovf"}, 32'(overflow_o), ovf);
    chk({tag, "_udf"}, 32'(underflow_o), udf);
  endtask

  initial begin
    // 1: reset
    tick();
    rst_i = 1'b0;
    chk("rst_usage", 32'(usage_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_ae", 32'(almost_empty_o), 1);
    chk("rst_af", 32'(almost_full_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk_flags("rst", 0, 0);

    // 2: fill to full, then one dropped push
    for (int i = 0; i < 5; i++) begin
      push_i = 1'b1;
      data_i = DW'(8'h11 + i);
      tick();
      chk("fill_usage", 32'(usage_o), 32'(i + 1));
      chk("fill_af", 32'(almost_full_o), (i + 1 >= 4) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty_o), (i + 1 <= 1) ? 1 : 0);
      chk("fill_full", 32'(full_o), (i + 1 == 5) ? 1 : 0);
      chk("fill_head", 32'(data_o), 32'h11);
    end
    data_i = 8'h16;
    tick();
    push_i = 1'b0;
    chk("ovf_usage", 32'(usage_o), 5);
    chk_flags("ovf", 1, 0);

    // 3: drain in order, then underflow
    for (int i = 0; i < 5; i++) begin
      chk("drain_head", 32'(data_o), 32'(8'h11 + i));
      pop_i = 1'b1;
      tick();
      chk("drain_usage", 32'(usage_o), 32'(4 - i));
    end
    pop_i = 1'b0;
    chk("drain_empty", 32'(empty_o), 1);
    chk("drain_data0", 32'(data_o), 0);
    chk_flags("drained", 1, 0);
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    chk("udf_usage", 32'(usage_o), 0);
    chk_flags("udf", 1, 1);

    // flush clears sticky flags; push in flush cycle is dropped silently
    flush_i = 1'b1;
    push_i  = 1'b1;
    data_i  = 8'h77;
    tick();
    flush_i = 1'b0;
    push_i  = 1'b0;
    chk("flush_usage", 32'(usage_o), 0);
    chk("flush_empty", 32'(empty_o), 1);
    chk_flags("flush", 0, 0);

    // 4: steady push+pop at usage 2 across the 4->0 wrap
    for (int i = 0; i < 2; i++) begin
      push_i = 1'b1;
      data_i = DW'(8'h20 + i);
      tick();
    end
    chk("wrap_pre_usage", 32'(usage_o), 2);
    pop_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("wrap_head", 32'(data_o), 32'(8'h20 + k));
      data_i = DW'(8'h22 + k);
      tick();
      chk("wrap_usage", 32'(usage_o), 2);
    end
    push_i = 1'b0;
    pop_i  = 1'b0;
    chk("wrap_tail", 32'(data_o), 32'h2c);
    chk_flags("wrap", 0, 0);

    // 5: full with push+pop -> pop wins, push dropped
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_i = 1'b1;
      data_i = DW'(8'h30 + i);
      tick();
    end
    chk("full5_full", 32'(full_o), 1);
    pop_i  = 1'b1;
    data_i = 8'h35;
    tick();
    push_i = 1'b0;
    pop_i  = 1'b0;
    chk("fullpp_usage", 32'(usage_o), 4);
    chk("fullpp_head", 32'(data_o), 32'h31);
    chk_flags("fullpp", 1, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush2_usage", 32'(usage_o), 0);
    chk_flags("flush2", 0, 0);

    // 6: push+pop on empty
    push_i = 1'b1;
    pop_i  = 1'b1;
    data_i = 8'hA5;
    #1;
`ifdef FIFO_V3_FALL_THROUGH_EN
    chk("ft_data", 32'(data_o), 32'hA5);
    chk("ft_empty", 32'(empty_o), 0);
    tick();
    push_i = 1'b0;
    pop_i  = 1'b0;
    chk("ft_usage", 32'(usage_o), 0);
    chk_flags("ft", 0, 0);
`else
    chk("noft_data", 32'(data_o), 0);
    chk("noft_empty", 32'(empty_o), 1);
    tick();
    push_i = 1'b0;
    pop_i  = 1'b0;
    chk("noft_usage", 32'(usage_o), 1);
    chk("noft_head", 32'(data_o), 32'hA5);
    chk_flags("noft", 0, 1);
`endif

    // reset clears everything again
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst2_usage", 32'(usage_o), 0);
    chk("rst2_data", 32'(data_o), 0);
    chk_flags("rst2", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
